alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the combinational ALU in the CPU core.
- Takes every parallel ALU result plus the operation code, selects the result, computes N/Z/C/V and registers them in a status register, and drives the register-file write port.
- Drives the ALU carry input, so ADC uses the stored C flag.
- MUL writes two registers (low half to rd, high half to rd+1) over two consecutive cycles.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register-file address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage can accept this cycle.
- op  in  4  operation code (encodings in package).
- rd  in  RADDR  destination register.
- flags_we  in  1  operation updates flags.
- x, y  in  XLEN  ALU operands (needed for C/V).
- summ, sub, mult_h, mult_l, zand, zor, zxor, znot, ashiftl, ashiftr, lshiftl, lshiftr  in  XLEN  ALU results.
- ocarry  in  1  ALU add carry-out.
- alu_carry  out  1  carry input to ALU.
- wb_we  out  1  register-file write strobe.
- wb_addr  out  RADDR  write address.
- wb_data  out  XLEN  write data.
- flags  out  4  {N,Z,C,V} status register.
- err  out  1  one-cycle pulse on reserved op.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: wb_we=0, wb_addr=0, wb_data=0, flags=0, err=0, state IDLE. in_ready=0 while rst is high.
- Op encoding:
  - 0 ADD, 1 ADC, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 NOT.
  - 8 ASL (ashiftl), 9 ASR, 10 LSL, 11 LSR.
  - 12-15 reserved.
- alu_carry (combinational): (op==ADC) & flags.C; 0 otherwise.
- Accept: in_valid & in_ready at a rising edge. The result is registered at that edge, so wb_we is high the following cycle. Latency is 1 cycle.
- States:
  - IDLE: in_ready=1. On accept of a non-MUL op → WB. On MUL → WB_LO. On reserved op → IDLE with err=1 the next cycle.
  - WB: wb_we=1; in_ready=1. Accept next op same cycle (throughput 1/cycle); otherwise → IDLE.
  - WB_LO: wb_we=1, wb_addr=rd, wb_data=mult_l captured; in_ready=0; → WB_HI unconditionally.
  - WB_HI: wb_we=1, wb_addr=(rd+1) mod 2^RADDR, wb_data=mult_h captured; in_ready=1; accept follows the same rules as IDLE.
- Reserved op: accepted; no write; flags unchanged.
- Flags are written at the accept edge when flags_we=1; otherwise held. A back-to-back ADC therefore sees the C from the preceding op.
  - N = result[XLEN-1]; Z = (result==0). For MUL: Z is on the full 2*XLEN product, N = mult_h[MSB].
  - ADD/ADC: C=ocarry; V=(x[MSB]==y[MSB]) & (summ[MSB]!=x[MSB]).
  - SUB: C = (x >= y) unsigned, i.e. no borrow; V=(x[MSB]!=y[MSB]) & (sub[MSB]!=x[MSB]).
  - MUL: V=(mult_h!=0); C unchanged.
  - AND/OR/XOR/NOT: C,V unchanged.
  - Shifts: C unchanged, V=0.
- Reset mid-MUL: the pending high-half write is discarded; no write after rst deasserts.
- rd=31 with MUL: high half writes register 0 (wrap). The register file decides whether r0 is writable.

Decomposition:
- Package cpu_alu_pkg:
  - op enum (ALU_ADD..ALU_LSR).
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - writeback state enum.
  - XLEN default.
- One combinational sub-module, alu_flag_calc: inputs op, x, y, result bus, ocarry, old flags; output next flags. The result-select mux and FSM stay in alu_writeback.

Test Plan:
- ADD x=2, y=6, summ=8, flags_we=1, rd=3 → next cycle wb_we=1, wb_addr=3, wb_data=8; flags=0000.
- ADD x=y=FFFF_FFFF (summ=FFFF_FFFE, ocarry=1), then ADC x=2, y=6 back-to-back → flags.C=1 after first; alu_carry=1 during ADC; N=1, V=0 after first.
- MUL x=y=7FFF_FFFF (mult_h=3FFF_FFFF, mult_l=1), rd=31 → write (31, 0000_0001), then (0, 3FFF_FFFF); in_ready=0 in the first write cycle; V=1. An op offered during the stall waits.
- SUB x=10, y=0xFFFF_FFEC (sub=30) → wb_data=30; C=0 (borrow), V=0, N=0, Z=0. Then SUB x=y=5 → Z=1, C=1.
- Reserved op 13 with flags_we=1 → err pulses one cycle, wb_we stays 0, flags unchanged.
- Assert rst during WB_LO of a MUL → wb_we=0 immediately and no high-half write afterwards; flags=0.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared types and constants for the ALU writeback stage:
// opcodes, flag bit positions and writeback FSM states.
package cpu_alu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RADDR_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_MUL = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_NOT = 4'd7,
        ALU_ASL = 4'd8,
        ALU_ASR = 4'd9,
        ALU_LSL = 4'd10,
        ALU_LSR = 4'd11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_WB_LO,
        ST_WB_HI
    } wb_state_e;

    // Codes above the last shift are reserved.
    function automatic logic op_reserved(input logic [3:0] op);
        return op > 4'(ALU_LSR);
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Upstream ALU result bus plus the writeback/status outputs of the stage.
interface alu_writeback_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [RADDR-1:0] rd;
    logic             flags_we;
    logic [XLEN-1:0]  x, y;
    logic [XLEN-1:0]  summ, sub, mult_h, mult_l;
    logic [XLEN-1:0]  zand, zor, zxor, znot;
    logic [XLEN-1:0]  ashiftl, ashiftr, lshiftl, lshiftr;
    logic             ocarry;
    logic             alu_carry;
    logic             wb_we;
    logic [RADDR-1:0] wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, op, rd, flags_we, x, y, summ, sub, mult_h, mult_l,
               zand, zor, zxor, znot, ashiftl, ashiftr, lshiftl, lshiftr, ocarry,
        input  in_ready, alu_carry, wb_we, wb_addr, wb_data, flags, err
    );

    modport slave (
        input  in_valid, op, rd, flags_we, x, y, summ, sub, mult_h, mult_l,
               zand, zor, zxor, znot, ashiftl, ashiftr, lshiftl, lshiftr, ocarry,
        output in_ready, alu_carry, wb_we, wb_addr, wb_data, flags, err
    );
endinterface

// File: rtl/alu_flag_calc.sv
// Next {N,Z,C,V} from the selected result; for MUL i_result is the low half
// and i_mult_h the high half of the product.
module alu_flag_calc
    import cpu_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_x,
    input  logic [XLEN-1:0] i_y,
    input  logic [XLEN-1:0] i_result,
    input  logic [XLEN-1:0] i_mult_h,
    input  logic            i_ocarry,
    input  logic [3:0]      i_flags,
    output logic [3:0]      o_flags
);
    localparam int MSB = XLEN - 1;

    logic w_n, w_z;
    assign w_n = i_result[MSB];
    assign w_z = (i_result == '0);

    always_comb begin
        o_flags = i_flags;
        case (i_op)
            ALU_ADD, ALU_ADC: begin
                o_flags[FLAG_N] = w_n;
                o_flags[FLAG_Z] = w_z;
                o_flags[FLAG_C] = i_ocarry;
                o_flags[FLAG_V] = (i_x[MSB] == i_y[MSB]) && (i_result[MSB] != i_x[MSB]);
            end
            ALU_SUB: begin
                o_flags[FLAG_N] = w_n;
                o_flags[FLAG_Z] = w_z;
                o_flags[FLAG_C] = (i_x >= i_y);
                o_flags[FLAG_V] = (i_x[MSB] != i_y[MSB]) && (i_result[MSB] != i_x[MSB]);
            end
            ALU_MUL: begin
                o_flags[FLAG_N] = i_mult_h[MSB];
                o_flags[FLAG_Z] = w_z && (i_mult_h == '0);
                o_flags[FLAG_V] = (i_mult_h != '0);
            end
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: begin
                o_flags[FLAG_N] = w_n;
                o_flags[FLAG_Z] = w_z;
            end
            ALU_ASL, ALU_ASR, ALU_LSL, ALU_LSR: begin
                o_flags[FLAG_N] = w_n;
                o_flags[FLAG_Z] = w_z;
                o_flags[FLAG_V] = 1'b0;
            end
            default: o_flags = i_flags;
        endcase
    end
endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: selects the result, keeps the status register and
// drives the register-file write port; MUL writes rd then rd+1.
module alu_writeback
    import cpu_alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    alu_writeback_if.slave bus
);
    wb_state_e        r_state, w_next;
    logic [XLEN-1:0]  w_result, r_wb_data, r_hi_data;
    logic [RADDR-1:0] r_wb_addr, r_hi_addr;
    logic [3:0]       r_flags, w_flags_nxt;
    logic             r_err, w_accept, w_rsvd, w_mul, w_ready;

    assign w_rsvd   = op_reserved(bus.op);
    assign w_mul    = (bus.op == ALU_MUL);
    assign w_ready  = !rst && (r_state != ST_WB_LO);
    assign w_accept = bus.in_valid && w_ready;

    always_comb begin
        w_result = '0;
        case (bus.op)
            ALU_ADD, ALU_ADC: w_result = bus.summ;
            ALU_SUB:          w_result = bus.sub;
            ALU_MUL:          w_result = bus.mult_l;
            ALU_AND:          w_result = bus.zand;
            ALU_OR:           w_result = bus.zor;
            ALU_XOR:          w_result = bus.zxor;
            ALU_NOT:          w_result = bus.znot;
            ALU_ASL:          w_result = bus.ashiftl;
            ALU_ASR:          w_result = bus.ashiftr;
            ALU_LSL:          w_result = bus.lshiftl;
            ALU_LSR:          w_result = bus.lshiftr;
            default:          w_result = '0;
        endcase
    end

    alu_flag_calc #(.XLEN(XLEN)) u_flags (
        .i_op     (bus.op),
        .i_x      (bus.x),
        .i_y      (bus.y),
        .i_result (w_result),
        .i_mult_h (bus.mult_h),
        .i_ocarry (bus.ocarry),
        .i_flags  (r_flags),
        .o_flags  (w_flags_nxt)
    );

    // WB_LO always hands over to WB_HI; every other state behaves like IDLE on accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WB_LO: w_next = ST_WB_HI;
            default: begin
                if (!w_accept)   w_next = ST_IDLE;
                else if (w_rsvd) w_next = ST_IDLE;
                else if (w_mul)  w_next = ST_WB_LO;
                else             w_next = ST_WB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_hi_addr <= '0;
            r_hi_data <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && w_rsvd;
            if (r_state == ST_WB_LO) begin
                r_wb_addr <= r_hi_addr;
                r_wb_data <= r_hi_data;
            end else if (w_accept && !w_rsvd) begin
                r_wb_addr <= bus.rd;
                r_wb_data <= w_result;
                r_hi_addr <= bus.rd + RADDR'(1);
                r_hi_data <= bus.mult_h;
            end
            if (w_accept && !w_rsvd && bus.flags_we)
                r_flags <= w_flags_nxt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.alu_carry = (bus.op == ALU_ADC) && r_flags[FLAG_C];
    assign bus.wb_we     = (r_state != ST_IDLE);
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_data   = r_wb_data;
    assign bus.flags     = r_flags;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: expected writes queued at offer time and
// popped by a write monitor; flags/handshake checked inline.
module tb_alu_writeback;
    import cpu_alu_pkg::*;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_writeback_if #(.XLEN(XLEN), .RADDR(RADDR)) bus ();

    alu_writeback #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RADDR-1:0] a;
        logic [XLEN-1:0]  d;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.wb_we === 1'b1) begin
            chk("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("wb_addr", 64'(bus.wb_addr), 64'(mon_e.a));
                chk("wb_data", 64'(bus.wb_data), 64'(mon_e.d));
            end
        end
    end

    task automatic offer(input logic [3:0] op, input logic [RADDR-1:0] rd, input logic fwe,
                         input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input logic cin,
                         input int nwr, input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi);
        logic [XLEN:0]     s;
        logic [2*XLEN-1:0] p;
        wr_t               e;
        int                n;
        s = {1'b0, x} + {1'b0, y} + (XLEN+1)'(cin);
        p = {{XLEN{1'b0}}, x} * {{XLEN{1'b0}}, y};
        bus.op       = op;
        bus.rd       = rd;
        bus.flags_we = fwe;
        bus.x        = x;
        bus.y        = y;
        bus.summ     = s[XLEN-1:0];
        bus.ocarry   = s[XLEN];
        bus.sub      = x - y;
        bus.mult_h   = p[2*XLEN-1:XLEN];
        bus.mult_l   = p[XLEN-1:0];
        bus.zand     = x & y;
        bus.zor      = x | y;
        bus.zxor     = x ^ y;
        bus.znot     = ~x;
        bus.ashiftl  = x << y[4:0];
        bus.ashiftr  = $signed(x) >>> y[4:0];
        bus.lshiftl  = x << y[4:0];
        bus.lshiftr  = x >> y[4:0];
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 64'(n < 20), 64'd1);
        chk("alu_carry", 64'(bus.alu_carry), 64'(cin));
        if (nwr > 0) begin
            e.a = rd;
            e.d = lo;
            sb.push_back(e);
        end
        if (nwr > 1) begin
            e.a = rd + RADDR'(1);
            e.d = hi;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op = '0; bus.rd = '0; bus.flags_we = 1'b0; bus.x = '0; bus.y = '0;
        bus.summ = '0; bus.sub = '0; bus.mult_h = '0; bus.mult_l = '0;
        bus.zand = '0; bus.zor = '0; bus.zxor = '0; bus.znot = '0;
        bus.ashiftl = '0; bus.ashiftr = '0; bus.lshiftl = '0; bus.lshiftr = '0;
        bus.ocarry = 1'b0;

        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_wb_we",    64'(bus.wb_we),    64'd0);
        chk("rst_wb_addr",  64'(bus.wb_addr),  64'd0);
        chk("rst_wb_data",  64'(bus.wb_data),  64'd0);
        chk("rst_flags",    64'(bus.flags),    64'd0);
        chk("rst_err",      64'(bus.err),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        offer(ALU_ADD, 5'd3, 1'b1, 32'd2, 32'd6, 1'b0, 1, 32'd8, 32'd0);
        chk("add_flags", 64'(bus.flags), 64'b0000);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        offer(ALU_ADD, 5'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFE, 32'd0);
        chk("add_carry_flags", 64'(bus.flags), 64'b1010);
        offer(ALU_ADC, 5'd5, 1'b1, 32'd2, 32'd6, 1'b1, 1, 32'd9, 32'd0);
        chk("adc_flags", 64'(bus.flags), 64'b0000);

        offer(ALU_MUL, 5'd31, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 2, 32'h0000_0001, 32'h3FFF_FFFF);
        chk("mul_stall_ready", 64'(bus.in_ready), 64'd0);
        chk("mul_lo_we",       64'(bus.wb_we),    64'd1);
        chk("mul_flags",       64'(bus.flags),    64'b0001);
        offer(ALU_AND, 5'd7, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1, 32'h0000_00F0, 32'd0);
        chk("and_flags", 64'(bus.flags), 64'b0001);
        offer(ALU_ASR, 5'd2, 1'b1, 32'h8000_0000, 32'd4, 1'b0, 1, 32'hF800_0000, 32'd0);
        chk("asr_flags", 64'(bus.flags), 64'b1000);

        offer(ALU_SUB, 5'd6, 1'b1, 32'd10, 32'hFFFF_FFEC, 1'b0, 1, 32'd30, 32'd0);
        chk("sub_borrow_flags", 64'(bus.flags), 64'b0000);
        offer(ALU_SUB, 5'd8, 1'b1, 32'd5, 32'd5, 1'b0, 1, 32'd0, 32'd0);
        chk("sub_zero_flags", 64'(bus.flags), 64'b0110);

        offer(4'd13, 5'd9, 1'b1, 32'd1, 32'd1, 1'b0, 0, 32'd0, 32'd0);
        chk("rsvd_err",   64'(bus.err),   64'd1);
        chk("rsvd_wb_we", 64'(bus.wb_we), 64'd0);
        chk("rsvd_flags", 64'(bus.flags), 64'b0110);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rsvd_err_pulse", 64'(bus.err), 64'd0);

        offer(ALU_MUL, 5'd10, 1'b1, 32'd3, 32'd5, 1'b0, 0, 32'd15, 32'd0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rstmul_wb_we",    64'(bus.wb_we),    64'd0);
        chk("rstmul_flags",    64'(bus.flags),    64'd0);
        chk("rstmul_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmul_no_hi_write", 64'(bus.wb_we), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
